// File: rtl/fadd_stream_accum.sv
// Streaming FP accumulator: folds one element per cycle into a running sum and
// emits the packet sum and beat count on the last beat.
`default_nettype none

module fadd_sub #(
  parameter int I_EXP  = 8,
  parameter int I_MNT  = 23,
  parameter int I_DATA = I_EXP + I_MNT + 1
) (
  input  logic [I_DATA-1:0] a_operand,
  input  logic [I_DATA-1:0] b_operand,
  input  logic              sub,
  output logic [I_DATA-1:0] result
);
  localparam int MW  = I_MNT + 1;
  localparam int W   = MW + 3;
  localparam int EW  = I_EXP + 2;
  localparam int LZW = $clog2(W + 1);
  localparam logic [I_EXP-1:0] W_E  = I_EXP'(W);
  localparam logic [EW-1:0]    EMAX = EW'((1 << I_EXP) - 1);

  logic             sa, sb, sx, a_big;
  logic [I_EXP-1:0] ea, eb, ex, ey, d, dd;
  logic [MW-1:0]    ma, mb, mx, my, mr_lo;
  logic [2*W-1:0]   sh;
  logic [W-1:0]     mx_al, my_al, norm;
  logic [W:0]       sum;
  logic [LZW-1:0]   lz;
  logic [EW-1:0]    exp_n, exp_r;
  logic [MW:0]      mr;
  logic [I_MNT-1:0] frac;
  logic             up;

  function automatic logic [LZW-1:0] lzc(input logic [W-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(W);
    for (int i = 0; i < W; i++) if (v[i]) n = LZW'(W - 1 - i);
    return n;
  endfunction

  always_comb begin
    sa = a_operand[I_DATA-1];
    sb = b_operand[I_DATA-1] ^ sub;
    ea = a_operand[I_DATA-2:I_MNT];
    eb = b_operand[I_DATA-2:I_MNT];
    // Denormals are flushed: a zero exponent reads as a zero magnitude.
    ma = (ea == '0) ? '0 : {1'b1, a_operand[I_MNT-1:0]};
    mb = (eb == '0) ? '0 : {1'b1, b_operand[I_MNT-1:0]};
    a_big = {ea, ma} >= {eb, mb};
    sx = a_big ? sa : sb;
    ex = a_big ? ea : eb;
    mx = a_big ? ma : mb;
    ey = a_big ? eb : ea;
    my = a_big ? mb : ma;
    d  = ex - ey;
    dd = (d > W_E) ? W_E : d;
    sh = {my, 3'b000, {W{1'b0}}} >> dd;
    my_al = sh[2*W-1:W] | {{(W-1){1'b0}}, |sh[W-1:0]};
    mx_al = {mx, 3'b000};
    sum = ((a_big ? sa : sb) ^ (a_big ? sb : sa)) ? {1'b0, mx_al} - {1'b0, my_al}
                                                  : {1'b0, mx_al} + {1'b0, my_al};
    lz = sum[W] ? '0 : lzc(sum[W-1:0]);
    norm = sum[W] ? {sum[W:2], sum[1] | sum[0]} : (sum[W-1:0] << lz);
    exp_n = {2'b00, ex} + {{(EW-1){1'b0}}, sum[W]} - {{(EW-LZW){1'b0}}, lz};
    // Round to nearest, ties to even, on guard/round/sticky.
    up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mr = {1'b0, norm[W-1:3]} + {{MW{1'b0}}, up};
    mr_lo = mr[MW-1:0];
    frac = mr[MW] ? mr[I_MNT:1] : mr_lo[I_MNT-1:0];
    exp_r = exp_n + {{(EW-1){1'b0}}, mr[MW]};
    if (sum == '0)
      result = '0;
    else if (exp_r[EW-1] || exp_r == '0)
      result = {sx, {(I_DATA-1){1'b0}}};
    else if (exp_r >= EMAX)
      result = {sx, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
    else
      result = {sx, exp_r[I_EXP-1:0], frac};
  end
endmodule

module fadd_stream_accum #(
  parameter int I_EXP  = 8,
  parameter int I_MNT  = 23,
  parameter int I_DATA = I_EXP + I_MNT + 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [I_DATA-1:0] in_data,
  input  logic              in_sub,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [I_DATA-1:0] out_data,
  output logic [CNT_W-1:0]  out_count
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [I_DATA-1:0] acc_q, acc_d, out_data_q, out_data_d, a_op, sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d, out_count_q, out_count_d, cnt_next;
  logic              accept;

  assign a_op   = (state_q == S_IDLE) ? '0 : acc_q;
  assign accept = in_valid && in_ready;

  fadd_sub #(.I_EXP(I_EXP), .I_MNT(I_MNT), .I_DATA(I_DATA)) u_fadd (
    .a_operand(a_op),
    .b_operand(in_data),
    .sub      (in_sub),
    .result   (sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = in_last ? S_DONE : S_ACCUM;
      S_ACCUM: if (accept && in_last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q != S_DONE);
    out_valid   = (state_q == S_DONE);
    out_data    = out_data_q;
    out_count   = out_count_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    // Saturating count; the first beat of a packet always counts as one.
    cnt_next = (state_q == S_IDLE) ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
    if (state_q == S_DONE) begin
      if (out_ready) begin
        acc_d = '0;
        cnt_d = '0;
      end
    end else if (accept) begin
      if (in_last) begin
        out_data_d  = sum;
        out_count_d = cnt_next;
      end else begin
        acc_d = sum;
        cnt_d = cnt_next;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_fadd_stream_accum.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized packets checked against a real-arithmetic reference.
`default_nettype none

module tb_fadd_stream_accum;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_sub, in_last, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, in_ready2, out_valid2;
  logic [31:0] out_data, out_data2;
  logic [15:0] out_count;
  logic [1:0]  out_count2;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fadd_stream_accum dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  fadd_stream_accum #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_count(out_count2)
  );

  typedef struct {
    logic [31:0] data;
    logic        sub;
    logic        last;
    logic [31:0] exp_d;
    logic [31:0] exp_c;
    logic [31:0] exp_c2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Real value to single-precision bits; inputs keep every sum exactly representable.
  function automatic logic [31:0] to_bits(input real r);
    real         a;
    int          e;
    logic        s;
    logic [7:0]  ex;
    longint      mant;
    logic [63:0] mv;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    ex = 8'(e + 127);
    mant = longint'((a - 1.0) * 8388608.0);
    mv = 64'(mant);
    return {s, ex, mv[22:0]};
  endfunction

  function automatic real rand_val();
    real r;
    r = real'($urandom_range(1, 2047)) / real'(1 << $urandom_range(0, 6));
    return ($urandom_range(0, 1) == 1) ? -r : r;
  endfunction

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [31:0] d, input logic s, input logic l);
    int n = 0;
    in_data = d; in_sub = s; in_last = l; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready stuck at %b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_pkt(input logic [31:0] ed, input logic [31:0] ec,
                           input logic [31:0] ec2, input int hold);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    chk("out_data", out_data, ed);
    chk("out_count", {16'h0, out_count}, ec);
    chk("out_valid2", 32'(out_valid2), 32'd1);
    chk("out_data2", out_data2, ed);
    chk("out_count2_sat", {30'h0, out_count2}, ec2);
    out_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, ed);
      chk("hold_in_ready", 32'(in_ready2), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{32'h3F800000, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0};
    tbl[1]  = '{32'h3F800000, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0};
    tbl[2]  = '{32'h3F800000, 1'b0, 1'b1, 32'h40400000, 32'd3, 32'd3};
    tbl[3]  = '{32'h40000000, 1'b1, 1'b1, 32'hC0000000, 32'd1, 32'd1};
    tbl[4]  = '{32'h3F800000, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0};
    tbl[5]  = '{32'h3F800000, 1'b1, 1'b1, 32'h00000000, 32'd2, 32'd2};
    tbl[6]  = '{32'h3F800000, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0};
    tbl[7]  = '{32'h3F800000, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0};
    tbl[8]  = '{32'h3F800000, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0};
    tbl[9]  = '{32'h3F800000, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0};
    tbl[10] = '{32'h3F800000, 1'b0, 1'b1, 32'h40A00000, 32'd5, 32'd3};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_count", {16'h0, out_count}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      send_beat(tbl[i].data, tbl[i].sub, tbl[i].last);
      if (tbl[i].last) check_pkt(tbl[i].exp_d, tbl[i].exp_c, tbl[i].exp_c2, 0);
    end

    // Backpressure with the next packet's beat waiting.
    send_beat(32'h40000000, 1'b0, 1'b0);
    send_beat(32'hBF800000, 1'b0, 1'b1);
    out_ready = 1'b0;
    in_data = 32'h3F800000; in_sub = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    chk("bp_data", out_data, 32'h3F800000);
    chk("bp_count", {16'h0, out_count}, 32'd2);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", out_data, 32'h3F800000);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_data", out_data, 32'h3F800000);
    chk("bp_next_count", {16'h0, out_count}, 32'd1);
    @(negedge clk);
    chk("bp_next_drop", 32'(out_valid), 32'd0);

    // Reset mid-packet discards the partial sum.
    send_beat(32'h40000000, 1'b0, 1'b0);
    send_beat(32'h40400000, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    send_beat(32'h3F800000, 1'b0, 1'b1);
    check_pkt(32'h3F800000, 32'd1, 32'd1, 0);

    // Reset while a sum is pending.
    send_beat(32'h40000000, 1'b0, 1'b1);
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    chk("donerst_valid", 32'(out_valid), 32'd0);
    chk("donerst_data", out_data, 32'h0);

    for (int p = 0; p < 40; p++) begin
      int  n;
      int  hold;
      real acc;
      real x;
      logic s;
      n = $urandom_range(1, 8);
      hold = $urandom_range(0, 3);
      acc = 0.0;
      for (int b = 0; b < n; b++) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0; in_data = $urandom;
          in_sub = 1'($urandom_range(0, 1)); in_last = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        x = rand_val();
        s = 1'($urandom_range(0, 1));
        acc = s ? acc - x : acc + x;
        send_beat(to_bits(x), s, b == n - 1);
      end
      check_pkt(to_bits(acc), 32'(n), 32'((n > 3) ? 3 : n), hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
